nonrestoring_div: RTL and testbench

Sequential signed integer divider, the inverse of the combinational Booth multiplier in the ALU's multiply/divide unit. It accepts a dividend and divisor on a start pulse, iterates one non-restoring quotient bit per clock, and returns quotient and remainder packed in the same 64-bit HI/LO layout the multiplier uses for its product. The ALU control FSM stalls on `busy` and latches the result on `done`.

---
 rtl/nonrestoring_div.sv | 122 ++++++++++++
 tb/tb_nonrestoring_div.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/nonrestoring_div.sv
// Sequential non-restoring divider: one quotient bit per clock, result packed {remainder, quotient}.
// Define DIV_SIGNED_EN for two's-complement signed division; otherwise operands are unsigned.
module nonrestoring_div #(
    parameter int unsigned REG_SIZE = 32
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  start,
    input  logic [REG_SIZE-1:0]   Q,
    input  logic [REG_SIZE-1:0]   M,
    output logic [2*REG_SIZE-1:0] result,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero
);

    localparam int unsigned CW = $clog2(REG_SIZE) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(REG_SIZE - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]          state;
    logic [CW-1:0]       count;
    logic [REG_SIZE:0]   a_reg;
    logic [REG_SIZE-1:0] q_reg;
    logic [REG_SIZE-1:0] m_reg;

    logic [REG_SIZE:0]   a_shift;
    logic [REG_SIZE:0]   a_step;
    logic [REG_SIZE-1:0] q_in;
    logic [REG_SIZE-1:0] m_in;
    logic [REG_SIZE-1:0] quot;
    logic [REG_SIZE-1:0] rem;

`ifdef DIV_SIGNED_EN
    logic q_neg;
    logic r_neg;
`endif

    always_comb begin
`ifdef DIV_SIGNED_EN
        q_in = Q[REG_SIZE-1] ? ('0 - Q) : Q;
        m_in = M[REG_SIZE-1] ? ('0 - M) : M;
`else
        q_in = Q;
        m_in = M;
`endif
        // Sign test uses A before the shift; the 33-bit wrap is harmless since the result fits.
        a_shift = {a_reg[REG_SIZE-1:0], q_reg[REG_SIZE-1]};
        if (!a_reg[REG_SIZE])
            a_step = a_shift - {1'b0, m_reg};
        else
            a_step = a_shift + {1'b0, m_reg};

        rem  = a_reg[REG_SIZE] ? (a_reg[REG_SIZE-1:0] + m_reg) : a_reg[REG_SIZE-1:0];
        quot = q_reg;
`ifdef DIV_SIGNED_EN
        if (q_neg)
            quot = '0 - q_reg;
        if (r_neg)
            rem = '0 - rem;
`endif
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state    <= IDLE;
            count    <= '0;
            a_reg    <= '0;
            q_reg    <= '0;
            m_reg    <= '0;
            result   <= '0;
            div_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (M == '0) begin
                            result   <= {Q, {REG_SIZE{1'b1}}};
                            div_zero <= 1'b1;
                            state    <= DONE;
                        end else begin
                            a_reg <= '0;
                            q_reg <= q_in;
                            m_reg <= m_in;
                            count <= '0;
`ifdef DIV_SIGNED_EN
                            q_neg <= Q[REG_SIZE-1] ^ M[REG_SIZE-1];
                            r_neg <= Q[REG_SIZE-1];
`endif
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    a_reg <= a_step;
                    q_reg <= {q_reg[REG_SIZE-2:0], ~a_step[REG_SIZE]};
                    count <= count + 1'b1;
                    if (count == LAST_ITER)
                        state <= FIX;
                end
                FIX: begin
                    result   <= {rem, quot};
                    div_zero <= 1'b0;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_nonrestoring_div.sv
// Scoreboard bench for nonrestoring_div: stimulus pushes expected {result, div_zero, done cycle},
// a negedge monitor pops and compares on every done pulse.
module tb_nonrestoring_div;

    logic        clock;
    logic        clear_n;
    logic        start;
    logic [31:0] Q;
    logic [31:0] M;
    logic [63:0] result;
    logic        busy;
    logic        done;
    logic        div_zero;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int unsigned due;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    nonrestoring_div #(.REG_SIZE(32)) dut (
        .clock    (clock),
        .clear_n  (clear_n),
        .start    (start),
        .Q        (Q),
        .M        (M),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (clear_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", result, e.res);
                check("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
                check("done_latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            check("done_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic push_exp(input logic [63:0] res, input logic dz, input int unsigned due);
        exp_t e;
        e.res = res;
        e.dz  = dz;
        e.due = due;
        exp_q.push_back(e);
    endtask

    // Called #1 after a clock edge with the DUT idle.
    task automatic run_div(input logic [31:0] q, input logic [31:0] m,
                           input logic [63:0] exp_res, input logic exp_dz);
        start = 1'b1;
        Q = q;
        M = m;
        @(posedge clock); #1;
        start = 1'b0;
        Q = $urandom;
        M = $urandom;
        push_exp(exp_res, exp_dz, exp_dz ? cyc : cyc + 33);
        check("busy_after_accept", {63'd0, busy}, 64'd1);
        wait_drain();
        check("done_fell", {63'd0, done}, 64'd0);
        check("busy_fell", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        clear_n = 1'b0;
        start   = 1'b0;
        Q       = '0;
        M       = '0;
        #12;
        check("reset_result", result, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_div_zero", {63'd0, div_zero}, 64'd0);
        clear_n = 1'b1;
        @(posedge clock); #1;

        run_div(32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
        run_div(32'd7, 32'd100, 64'h00000007_00000000, 1'b0);
        run_div(32'd0, 32'd5, 64'h00000000_00000000, 1'b0);
        run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h00000000_00000001, 1'b0);
`ifdef DIV_SIGNED_EN
        run_div(32'hFFFF_FF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 1'b0);
        run_div(32'd100, 32'hFFFF_FFF9, 64'h00000002_FFFFFFF2, 1'b0);
        run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFFFFFE_0000000E, 1'b0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 1'b0);
        run_div(32'hFFFF_FFFF, 32'd2, 64'hFFFFFFFF_00000000, 1'b0);
`else
        run_div(32'hFFFF_FF9C, 32'd7, 64'h00000002_24924916, 1'b0);
        run_div(32'd100, 32'hFFFF_FFF9, 64'h00000064_00000000, 1'b0);
        run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFFFF9C_00000000, 1'b0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000, 1'b0);
        run_div(32'hFFFF_FFFF, 32'd2, 64'h00000001_7FFFFFFF, 1'b0);
`endif
        run_div(32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1);
        run_div(32'hFFFF_FF9C, 32'd0, 64'hFFFFFF9C_FFFFFFFF, 1'b1);

        // Divide-by-zero then a held start: next accept only two edges later, div_zero cleared.
        begin
            int unsigned e;
            start = 1'b1;
            Q = 32'd5;
            M = 32'd0;
            @(posedge clock); #1;
            e = cyc;
            push_exp(64'h00000005_FFFFFFFF, 1'b1, e);
            Q = 32'd49;
            M = 32'd7;
            @(posedge clock); #1;
            @(posedge clock); #1;
            start = 1'b0;
            push_exp(64'h00000000_00000007, 1'b0, e + 2 + 33);
            wait_drain();
        end

        // Start pulses while busy must be ignored, including in FIX and DONE.
        start = 1'b1;
        Q = 32'd100;
        M = 32'd7;
        @(posedge clock); #1;
        push_exp(64'h00000002_0000000E, 1'b0, cyc + 33);
        for (int i = 1; i <= 40; i++) begin
            start = (i == 5 || i == 33 || i == 34);
            Q = 32'd9;
            M = 32'd3;
            @(posedge clock); #1;
        end
        start = 1'b0;
        check("repulse_drained", 64'(exp_q.size()), 64'd0);
        check("repulse_result_held", result, 64'h00000002_0000000E);
        check("repulse_idle", {63'd0, busy}, 64'd0);

        // Asynchronous reset mid-division abandons it without a done pulse.
        run_div(32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1);
        start = 1'b1;
        Q = 32'd100;
        M = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        clear_n = 1'b0;
        #1;
        check("midreset_result", result, 64'd0);
        check("midreset_busy", {63'd0, busy}, 64'd0);
        check("midreset_done", {63'd0, done}, 64'd0);
        check("midreset_div_zero", {63'd0, div_zero}, 64'd0);
        repeat (3) @(posedge clock);
        #2;
        clear_n = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        run_div(32'd49, 32'd7, 64'h00000000_00000007, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
